// File: rtl/int_alu_issue_arbiter_pkg.sv
// Shared definitions for the integer ALU issue path.
// - to_execution: op record carried from a reservation station to int_alu.
// - alu_op_class_e / classify_alu_op: result-latency class of an op. This must
//   decode exactly the way int_alu does, so both blocks import it from here.
// - MUL_LAT / DIV_LAT: issue-to-writeback latencies. SLOTS is derived from them.
package int_alu_issue_arbiter_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned MUL_LAT = 3;
  localparam int unsigned DIV_LAT = 16;
  localparam int unsigned SLOTS   = DIV_LAT + 1;

  localparam logic [4:0] UOP_MUL_FIRST = 5'b00010;
  localparam logic [4:0] UOP_MUL_LAST  = 5'b00101;
  localparam logic [4:0] UOP_DIV       = 5'b00110;
  localparam logic [4:0] UOP_REM       = 5'b01000;
  localparam logic [4:0] UOP_REMU      = 5'b01001;

  typedef struct packed {
    logic [4:0]      microoperation;
    logic [XLEN-1:0] data1;
    logic [XLEN-1:0] data2;
    logic [5:0]      destination;
    logic [3:0]      ticket;
  } to_execution;

  typedef enum logic [1:0] {OP_1CYC, OP_MUL, OP_DIV} alu_op_class_e;

  // Divide by zero and the signed 1 / -1 case finish in one cycle inside
  // int_alu, so they never occupy the divider or a writeback slot.
  function automatic alu_op_class_e classify_alu_op(input to_execution op);
    alu_op_class_e cls;
    logic          is_signed;
    cls       = OP_1CYC;
    is_signed = (op.microoperation == UOP_DIV) || (op.microoperation == UOP_REM);
    if (op.microoperation >= UOP_MUL_FIRST && op.microoperation <= UOP_MUL_LAST) begin
      cls = OP_MUL;
    end else if (op.microoperation >= UOP_DIV && op.microoperation <= UOP_REMU) begin
      if (op.data2 == '0) begin
        cls = OP_1CYC;
      end else if (is_signed && op.data1 == {{(XLEN-1){1'b0}}, 1'b1} && op.data2 == '1) begin
        cls = OP_1CYC;
      end else begin
        cls = OP_DIV;
      end
    end
    return cls;
  endfunction

endpackage

// File: rtl/int_alu_issue_arbiter_if.sv
// Handshake bundle between two integer reservation stations, the issue arbiter
// and int_alu.
// - rs0_valid/rs0_data/rs0_ready, rs1_valid/rs1_data/rs1_ready: per-port
//   valid/ready handshake; a transfer is valid & ready in the same cycle.
// - alu_valid/alu_data: op issued to int_alu this cycle.
// - alu_busy: int_alu divider occupied.
// slave is the arbiter's view; master is the view of its environment.
interface int_alu_issue_arbiter_if;
  import int_alu_issue_arbiter_pkg::*;

  logic        rs0_valid;
  to_execution rs0_data;
  logic        rs0_ready;
  logic        rs1_valid;
  to_execution rs1_data;
  logic        rs1_ready;
  logic        alu_valid;
  to_execution alu_data;
  logic        alu_busy;

  modport master (
    output rs0_valid, rs0_data, rs1_valid, rs1_data, alu_busy,
    input  rs0_ready, rs1_ready, alu_valid, alu_data
  );

  modport slave (
    input  rs0_valid, rs0_data, rs1_valid, rs1_data, alu_busy,
    output rs0_ready, rs1_ready, alu_valid, alu_data
  );

endinterface

// File: rtl/alu_wb_slot_tracker.sv
// Writeback-slot reservation vector for int_alu's single result port.
// Bit k of slot_q set means a MUL/DIV result lands k cycles from now.
// Ports:
// - clk, rst_n    : clock, asynchronous active-low reset (drops all reservations)
// - issue_valid   : an op is issued this cycle
// - issue_class   : latency class of the issued op
// - free_1cyc     : no result lands this cycle (a 1-cycle op may issue)
// - free_mul      : the MUL landing cycle is unclaimed
// - free_div      : the DIV landing cycle is unclaimed
module alu_wb_slot_tracker
  import int_alu_issue_arbiter_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          issue_valid,
  input  alu_op_class_e issue_class,
  output logic          free_1cyc,
  output logic          free_mul,
  output logic          free_div
);

  logic [SLOTS-1:0] slot_q, slot_d, issue_mask;

  // An op of latency L issued now lands L-1 cycles after the next edge, so its
  // bit goes in at L-1 of the next-state vector.
  always_comb begin
    issue_mask = '0;
    if (issue_valid) begin
      case (issue_class)
        OP_MUL:  issue_mask[MUL_LAT-1] = 1'b1;
        OP_DIV:  issue_mask[DIV_LAT-1] = 1'b1;
        default: issue_mask = '0;
      endcase
    end
    slot_d = (slot_q >> 1) | issue_mask;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign free_1cyc = ~slot_q[0];
  assign free_mul  = ~slot_q[MUL_LAT];
  assign free_div  = ~slot_q[DIV_LAT];

endmodule

// File: rtl/int_alu_issue_arbiter.sv
// Shares one int_alu between two reservation-station ports.
// Picks at most one op per cycle with round-robin preference, never lets two
// results reach the ALU result port in the same cycle, and never issues a DIV
// while the non-pipelined divider is occupied. Grants are combinational.
// Ports:
// - clk, rst_n : clock, asynchronous active-low reset
// - bus        : slave view of int_alu_issue_arbiter_if (RS handshakes, ALU
//                issue, alu_busy)
module int_alu_issue_arbiter
  import int_alu_issue_arbiter_pkg::*;
(
  input logic                    clk,
  input logic                    rst_n,
  int_alu_issue_arbiter_if.slave bus
);

  localparam int unsigned CntW = $clog2(DIV_LAT + 1);

  alu_op_class_e   cls0, cls1, grant_cls;
  logic            free_1cyc, free_mul, free_div, div_idle;
  logic            elig0, elig1, grant0, grant1, any_grant;
  logic            ptr_q, ptr_d;  // 0: RS0 preferred
  logic [CntW-1:0] div_cnt_q, div_cnt_d;

  function automatic logic op_eligible(input alu_op_class_e cls, input logic f1,
                                       input logic fm, input logic fd, input logic idle);
    logic ok;
    case (cls)
      OP_MUL:  ok = fm;
      OP_DIV:  ok = fd & idle;
      default: ok = f1;
    endcase
    return ok;
  endfunction

  assign cls0     = classify_alu_op(bus.rs0_data);
  assign cls1     = classify_alu_op(bus.rs1_data);
  assign div_idle = (div_cnt_q == '0) && !bus.alu_busy;

  always_comb begin
    elig0     = bus.rs0_valid & op_eligible(cls0, free_1cyc, free_mul, free_div, div_idle);
    elig1     = bus.rs1_valid & op_eligible(cls1, free_1cyc, free_mul, free_div, div_idle);
    // Work-conserving: the non-preferred port wins whenever the preferred cannot go.
    grant0    = elig0 & (~ptr_q | ~elig1);
    grant1    = elig1 & ~grant0;
    any_grant = grant0 | grant1;
    grant_cls = grant0 ? cls0 : cls1;

    ptr_d = ptr_q;
    if (grant0) begin
      ptr_d = 1'b1;
    end else if (grant1) begin
      ptr_d = 1'b0;
    end

    // Counts occupied cycles left after the issue cycle, so it reaches 0 in
    // the cycle the divider frees up and a new DIV can follow immediately.
    div_cnt_d = div_cnt_q;
    if (any_grant && grant_cls == OP_DIV) begin
      div_cnt_d = CntW'(DIV_LAT - 1);
    end else if (div_cnt_q != '0) begin
      div_cnt_d = div_cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q     <= 1'b0;
      div_cnt_q <= '0;
    end else begin
      ptr_q     <= ptr_d;
      div_cnt_q <= div_cnt_d;
    end
  end

  alu_wb_slot_tracker u_slot_tracker (
    .clk         (clk),
    .rst_n       (rst_n),
    .issue_valid (any_grant),
    .issue_class (grant_cls),
    .free_1cyc   (free_1cyc),
    .free_mul    (free_mul),
    .free_div    (free_div)
  );

  assign bus.rs0_ready = grant0;
  assign bus.rs1_ready = grant1;
  assign bus.alu_valid = any_grant;
  assign bus.alu_data  = grant0 ? bus.rs0_data : bus.rs1_data;

endmodule

// File: tb/tb_int_alu_issue_arbiter.sv
// Bench for int_alu_issue_arbiter. Each scenario builds a per-cycle stimulus
// table; applying a row pushes its expected handshake and ticket onto the
// scoreboard, which is popped and compared at the following falling edge.
module tb_int_alu_issue_arbiter;
  import int_alu_issue_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int_alu_issue_arbiter_if bus ();

  int_alu_issue_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  localparam logic [4:0] U_ADD  = 5'b00000;
  localparam logic [4:0] U_MUL  = 5'b00010;
  localparam logic [4:0] U_DIV  = 5'b00110;
  localparam logic [4:0] U_DIVU = 5'b00111;
  localparam logic [4:0] U_REM  = 5'b01000;
  localparam logic [4:0] U_REMU = 5'b01001;
  localparam logic [4:0] U_BAD  = 5'b11111;
  localparam logic [31:0] ONES  = 32'hFFFF_FFFF;

  // {rs0_ready, rs1_ready, alu_valid}
  localparam logic [2:0] G0   = 3'b101;
  localparam logic [2:0] G1   = 3'b011;
  localparam logic [2:0] NONE = 3'b000;

  typedef struct {
    logic        v0;
    to_execution op0;
    logic        v1;
    to_execution op1;
    logic        busy;
    logic [2:0]  hs;
    logic [3:0]  tkt;
  } row_t;

  typedef struct packed {
    logic [2:0] hs;
    logic [3:0] tkt;
  } exp_t;

  row_t tbl[$];
  exp_t sb[$];
  int   n_run  = 0;
  int   n_fail = 0;

  function automatic to_execution mk(input logic [4:0] u, input logic [31:0] a,
                                     input logic [31:0] b, input logic [3:0] t);
    to_execution o;
    o.microoperation = u;
    o.data1          = a;
    o.data2          = b;
    o.destination    = {2'b00, t};
    o.ticket         = t;
    return o;
  endfunction

  function automatic row_t r(input logic v0, input to_execution op0, input logic v1,
                             input to_execution op1, input logic busy,
                             input logic [2:0] hs, input logic [3:0] tkt);
    row_t x;
    x.v0 = v0; x.op0 = op0; x.v1 = v1; x.op1 = op1;
    x.busy = busy; x.hs = hs; x.tkt = tkt;
    return x;
  endfunction

  function automatic to_execution idle_op();
    return mk(U_ADD, 32'd0, 32'd0, 4'd0);
  endfunction

  // Drive one row and record what the DUT must show for it.
  task automatic apply(input row_t rw);
    bus.rs0_valid = rw.v0;
    bus.rs0_data  = rw.op0;
    bus.rs1_valid = rw.v1;
    bus.rs1_data  = rw.op1;
    bus.alu_busy  = rw.busy;
    sb.push_back({rw.hs, rw.tkt});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    apply(r(1'b0, idle_op(), 1'b0, idle_op(), 1'b0, NONE, 4'd0));
    void'(sb.pop_front());
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    exp_t e;
    rst_n = 1'b0;
    apply(r(1'b0, idle_op(), 1'b0, idle_op(), 1'b0, NONE, 4'd0));
    @(negedge clk);
    e = sb.pop_front();
    n_run++;
    if ({bus.rs0_ready, bus.rs1_ready, bus.alu_valid} !== e.hs) begin
      n_fail++;
      $display("FAIL reset_hold handshake got %b want %b",
               {bus.rs0_ready, bus.rs1_ready, bus.alu_valid}, e.hs);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tbl.delete();
    tbl.push_back(r(1'b0, idle_op(), 1'b0, idle_op(), 1'b0, NONE, 4'd0));
    tbl.push_back(r(1'b0, idle_op(), 1'b1, mk(U_ADD, 32'd1, 32'd2, 4'd2), 1'b0, G1, 4'd2));
    foreach (tbl[i]) begin
      apply(tbl[i]);
      @(negedge clk);
      e = sb.pop_front();
      n_run++;
      if ({bus.rs0_ready, bus.rs1_ready, bus.alu_valid} !== e.hs) begin
        n_fail++;
        $display("FAIL reset cyc %0d handshake got %b want %b", i,
                 {bus.rs0_ready, bus.rs1_ready, bus.alu_valid}, e.hs);
      end
      if (e.hs[0]) begin
        n_run++;
        if (bus.alu_data.ticket !== e.tkt) begin
          n_fail++;
          $display("FAIL reset cyc %0d ticket got %0d want %0d", i, bus.alu_data.ticket, e.tkt);
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_alternate();
    exp_t e;
    do_reset();
    tbl.delete();
    for (int k = 0; k < 4; k++) begin
      tbl.push_back(r(1'b1, mk(U_ADD, 32'd1, 32'd1, 4'd1), 1'b1, mk(U_ADD, 32'd2, 32'd2, 4'd2),
                      1'b0, (k % 2 == 0) ? G0 : G1, (k % 2 == 0) ? 4'd1 : 4'd2));
    end
    foreach (tbl[i]) begin
      apply(tbl[i]);
      @(negedge clk);
      e = sb.pop_front();
      n_run++;
      if ({bus.rs0_ready, bus.rs1_ready, bus.alu_valid} !== e.hs) begin
        n_fail++;
        $display("FAIL alternate cyc %0d handshake got %b want %b", i,
                 {bus.rs0_ready, bus.rs1_ready, bus.alu_valid}, e.hs);
      end
      if (e.hs[0]) begin
        n_run++;
        if (bus.alu_data.ticket !== e.tkt) begin
          n_fail++;
          $display("FAIL alternate cyc %0d ticket got %0d want %0d", i, bus.alu_data.ticket, e.tkt);
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_mul_slot();
    exp_t        e;
    to_execution add1;
    add1 = mk(U_ADD, 32'd4, 32'd4, 4'd4);
    do_reset();
    tbl.delete();
    tbl.push_back(r(1'b1, mk(U_MUL, 32'd3, 32'd4, 4'd3), 1'b1, add1, 1'b0, G0, 4'd3));
    tbl.push_back(r(1'b0, idle_op(), 1'b1, add1, 1'b0, G1, 4'd4));
    tbl.push_back(r(1'b0, idle_op(), 1'b1, add1, 1'b0, G1, 4'd4));
    tbl.push_back(r(1'b0, idle_op(), 1'b1, add1, 1'b0, NONE, 4'd0));  // MUL lands
    tbl.push_back(r(1'b0, idle_op(), 1'b1, add1, 1'b0, G1, 4'd4));
    foreach (tbl[i]) begin
      apply(tbl[i]);
      @(negedge clk);
      e = sb.pop_front();
      n_run++;
      if ({bus.rs0_ready, bus.rs1_ready, bus.alu_valid} !== e.hs) begin
        n_fail++;
        $display("FAIL mul_slot cyc %0d handshake got %b want %b", i,
                 {bus.rs0_ready, bus.rs1_ready, bus.alu_valid}, e.hs);
      end
      if (e.hs[0]) begin
        n_run++;
        if (bus.alu_data.ticket !== e.tkt) begin
          n_fail++;
          $display("FAIL mul_slot cyc %0d ticket got %0d want %0d", i, bus.alu_data.ticket, e.tkt);
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_div_busy();
    exp_t        e;
    to_execution div2, add1;
    div2 = mk(U_DIV, 32'd100, 32'd7, 4'd6);
    add1 = mk(U_ADD, 32'd1, 32'd1, 4'd7);
    do_reset();
    tbl.delete();
    tbl.push_back(r(1'b1, mk(U_DIV, 32'd100, 32'd7, 4'd5), 1'b0, idle_op(), 1'b0, G0, 4'd5));
    for (int k = 1; k <= 15; k++) tbl.push_back(r(1'b1, div2, 1'b1, add1, 1'b0, G1, 4'd7));
    tbl.push_back(r(1'b1, div2, 1'b1, add1, 1'b0, G0, 4'd6));  // first DIV lands, divider free
    tbl.push_back(r(1'b0, idle_op(), 1'b1, add1, 1'b0, G1, 4'd7));
    foreach (tbl[i]) begin
      apply(tbl[i]);
      @(negedge clk);
      e = sb.pop_front();
      n_run++;
      if ({bus.rs0_ready, bus.rs1_ready, bus.alu_valid} !== e.hs) begin
        n_fail++;
        $display("FAIL div_busy cyc %0d handshake got %b want %b", i,
                 {bus.rs0_ready, bus.rs1_ready, bus.alu_valid}, e.hs);
      end
      if (e.hs[0]) begin
        n_run++;
        if (bus.alu_data.ticket !== e.tkt) begin
          n_fail++;
          $display("FAIL div_busy cyc %0d ticket got %0d want %0d", i, bus.alu_data.ticket, e.tkt);
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  // alu_busy=1 inhibits only DIV-class ops, which exposes the classification.
  task automatic test_classify();
    exp_t e;
    do_reset();
    tbl.delete();
    tbl.push_back(r(1'b1, mk(U_DIV,  32'd100, 32'd7, 4'd1), 1'b0, idle_op(), 1'b1, NONE, 4'd0));
    tbl.push_back(r(1'b1, mk(U_DIVU, 32'd1,   ONES,  4'd1), 1'b0, idle_op(), 1'b1, NONE, 4'd0));
    tbl.push_back(r(1'b1, mk(U_DIV,  32'd2,   ONES,  4'd1), 1'b0, idle_op(), 1'b1, NONE, 4'd0));
    tbl.push_back(r(1'b1, mk(U_DIV,  32'd5,   32'd0, 4'd1), 1'b0, idle_op(), 1'b1, G0, 4'd1));
    tbl.push_back(r(1'b1, mk(U_REM,  32'd1,   ONES,  4'd2), 1'b0, idle_op(), 1'b1, G0, 4'd2));
    tbl.push_back(r(1'b1, mk(U_REMU, 32'd9,   32'd0, 4'd3), 1'b0, idle_op(), 1'b1, G0, 4'd3));
    tbl.push_back(r(1'b1, mk(U_DIV,  32'd1,   ONES,  4'd4), 1'b0, idle_op(), 1'b1, G0, 4'd4));
    tbl.push_back(r(1'b1, mk(U_BAD,  32'd3,   32'd3, 4'd5), 1'b0, idle_op(), 1'b1, G0, 4'd5));
    tbl.push_back(r(1'b1, mk(U_MUL,  32'd3,   32'd3, 4'd6), 1'b0, idle_op(), 1'b1, G0, 4'd6));
    tbl.push_back(r(1'b1, mk(U_DIV,  32'd100, 32'd7, 4'd7), 1'b0, idle_op(), 1'b0, G0, 4'd7));
    foreach (tbl[i]) begin
      apply(tbl[i]);
      @(negedge clk);
      e = sb.pop_front();
      n_run++;
      if ({bus.rs0_ready, bus.rs1_ready, bus.alu_valid} !== e.hs) begin
        n_fail++;
        $display("FAIL classify cyc %0d handshake got %b want %b", i,
                 {bus.rs0_ready, bus.rs1_ready, bus.alu_valid}, e.hs);
      end
      if (e.hs[0]) begin
        n_run++;
        if (bus.alu_data.ticket !== e.tkt) begin
          n_fail++;
          $display("FAIL classify cyc %0d ticket got %0d want %0d", i, bus.alu_data.ticket, e.tkt);
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_div_special();
    exp_t        e;
    to_execution sp1, add1;
    sp1  = mk(U_DIV, 32'd1, ONES, 4'd9);
    add1 = mk(U_ADD, 32'd1, 32'd1, 4'd11);
    do_reset();
    tbl.delete();
    tbl.push_back(r(1'b1, mk(U_DIV, 32'd5, 32'd0, 4'd8), 1'b1, sp1, 1'b0, G0, 4'd8));
    tbl.push_back(r(1'b0, idle_op(), 1'b1, sp1, 1'b0, G1, 4'd9));
    // Real DIV straight after: div_cnt must still be 0.
    tbl.push_back(r(1'b1, mk(U_DIV, 32'd100, 32'd7, 4'd10), 1'b1, add1, 1'b0, G0, 4'd10));
    // No reservation from the 1-cycle divides: slot[0] stays clear here.
    tbl.push_back(r(1'b0, idle_op(), 1'b1, add1, 1'b0, G1, 4'd11));
    tbl.push_back(r(1'b0, idle_op(), 1'b1, add1, 1'b0, G1, 4'd11));
    foreach (tbl[i]) begin
      apply(tbl[i]);
      @(negedge clk);
      e = sb.pop_front();
      n_run++;
      if ({bus.rs0_ready, bus.rs1_ready, bus.alu_valid} !== e.hs) begin
        n_fail++;
        $display("FAIL div_special cyc %0d handshake got %b want %b", i,
                 {bus.rs0_ready, bus.rs1_ready, bus.alu_valid}, e.hs);
      end
      if (e.hs[0]) begin
        n_run++;
        if (bus.alu_data.ticket !== e.tkt) begin
          n_fail++;
          $display("FAIL div_special cyc %0d ticket got %0d want %0d", i,
                   bus.alu_data.ticket, e.tkt);
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  // DIV issued at t1 lands at t17; a MUL offered at t14 would land there too.
  task automatic test_collision();
    exp_t        e;
    to_execution mul2, add1;
    mul2 = mk(U_MUL, 32'd6, 32'd7, 4'd3);
    add1 = mk(U_ADD, 32'd1, 32'd1, 4'd4);
    do_reset();
    tbl.delete();
    tbl.push_back(r(1'b1, mk(U_MUL, 32'd2, 32'd3, 4'd1), 1'b0, idle_op(), 1'b0, G0, 4'd1));
    tbl.push_back(r(1'b1, mk(U_DIV, 32'd100, 32'd7, 4'd2), 1'b0, idle_op(), 1'b0, G0, 4'd2));
    for (int k = 2; k <= 13; k++) tbl.push_back(r(1'b0, idle_op(), 1'b0, idle_op(), 1'b0, NONE, 4'd0));
    tbl.push_back(r(1'b1, add1, 1'b1, mul2, 1'b0, G0, 4'd4));        // t14: MUL held
    tbl.push_back(r(1'b0, idle_op(), 1'b1, mul2, 1'b0, G1, 4'd3));   // t15: MUL lands t18
    tbl.push_back(r(1'b1, add1, 1'b0, idle_op(), 1'b0, G0, 4'd4));   // t16
    tbl.push_back(r(1'b1, add1, 1'b0, idle_op(), 1'b0, NONE, 4'd0)); // t17: DIV lands
    tbl.push_back(r(1'b1, add1, 1'b0, idle_op(), 1'b0, NONE, 4'd0)); // t18: MUL lands
    tbl.push_back(r(1'b1, add1, 1'b0, idle_op(), 1'b0, G0, 4'd4));
    foreach (tbl[i]) begin
      apply(tbl[i]);
      @(negedge clk);
      e = sb.pop_front();
      n_run++;
      if ({bus.rs0_ready, bus.rs1_ready, bus.alu_valid} !== e.hs) begin
        n_fail++;
        $display("FAIL collision cyc %0d handshake got %b want %b", i,
                 {bus.rs0_ready, bus.rs1_ready, bus.alu_valid}, e.hs);
      end
      if (e.hs[0]) begin
        n_run++;
        if (bus.alu_data.ticket !== e.tkt) begin
          n_fail++;
          $display("FAIL collision cyc %0d ticket got %0d want %0d", i, bus.alu_data.ticket, e.tkt);
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset_mid();
    exp_t        e;
    to_execution div2, add1;
    div2 = mk(U_DIV, 32'd50, 32'd3, 4'd2);
    add1 = mk(U_ADD, 32'd1, 32'd1, 4'd3);
    do_reset();
    tbl.delete();
    tbl.push_back(r(1'b1, mk(U_DIV, 32'd100, 32'd7, 4'd1), 1'b0, idle_op(), 1'b0, G0, 4'd1));
    for (int k = 1; k <= 4; k++) tbl.push_back(r(1'b1, div2, 1'b0, idle_op(), 1'b0, NONE, 4'd0));
    // t5: reset asserted; ptr back to RS0 and div_cnt cleared at once.
    tbl.push_back(r(1'b1, div2, 1'b1, add1, 1'b0, G0, 4'd2));
    // First cycle after release: DIV granted.
    tbl.push_back(r(1'b1, div2, 1'b1, add1, 1'b0, G0, 4'd2));
    tbl.push_back(r(1'b0, idle_op(), 1'b1, add1, 1'b0, G1, 4'd3));
    foreach (tbl[i]) begin
      if (i == 5) rst_n = 1'b0;
      if (i == 6) rst_n = 1'b1;
      apply(tbl[i]);
      @(negedge clk);
      e = sb.pop_front();
      n_run++;
      if ({bus.rs0_ready, bus.rs1_ready, bus.alu_valid} !== e.hs) begin
        n_fail++;
        $display("FAIL reset_mid cyc %0d handshake got %b want %b", i,
                 {bus.rs0_ready, bus.rs1_ready, bus.alu_valid}, e.hs);
      end
      if (e.hs[0]) begin
        n_run++;
        if (bus.alu_data.ticket !== e.tkt) begin
          n_fail++;
          $display("FAIL reset_mid cyc %0d ticket got %0d want %0d", i, bus.alu_data.ticket, e.tkt);
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_alternate();
    test_mul_slot();
    test_div_busy();
    test_classify();
    test_div_special();
    test_collision();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
